// File: rtl/mem_col_wr_arbiter.sv
// Write arbiter and sequencer for one memory column: picks one requester, holds the row write for WR_CYCLES clocks.
// Build option MEM_COL_WR_ARB_FIXED_PRIO_EN: lowest-index requester always wins instead of round-robin.
module mem_col_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_ROWS   = 1024,
  parameter int DATA_WIDTH = 8,
  parameter int WR_CYCLES  = 2,
  localparam int AW        = $clog2(NUM_ROWS)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][AW-1:0]          req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [NUM_REQ-1:0]                  grant_o,
  output logic [AW-1:0]                       row_sel_o,
  output logic [DATA_WIDTH-1:0]               row_data_o,
  output logic                                row_we_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WR_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                 state_q;
  logic [IW-1:0]          rr_ptr_q;
  logic [IW-1:0]          win_q;
  logic [CW-1:0]          wr_cnt_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic [AW-1:0]          row_sel_q;
  logic [DATA_WIDTH-1:0]  row_data_q;
  logic                   row_we_q;

  logic [IW-1:0]          pick_idx_d;
  logic [NUM_REQ-1:0]     pick_onehot_d;
  logic [IW-1:0]          rr_ptr_d;
  logic                   last_cycle;

  // Scan downward through the rotated order so the final assignment is the
  // first valid requester at or above rr_ptr_q.
  always_comb begin : pick_search
    int            cand;
    logic [IW-1:0] cand_idx;
    pick_idx_d = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IW'(cand);
      if (req_valid_i[cand_idx]) begin
        pick_idx_d = cand_idx;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign pick_onehot_d[gi] = (pick_idx_d == IW'(gi));
    end
  endgenerate

`ifdef MEM_COL_WR_ARB_FIXED_PRIO_EN
  assign rr_ptr_d = '0;
`else
  assign rr_ptr_d = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
`endif

  assign last_cycle = (state_q == BUSY) && (wr_cnt_q == LAST_CNT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      win_q      <= '0;
      wr_cnt_q   <= '0;
      grant_q    <= '0;
      row_sel_q  <= '0;
      row_data_q <= '0;
      row_we_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      wr_cnt_q <= '0;
      if (|req_valid_i) begin
        // Payload is captured here only; later requester changes are ignored.
        win_q      <= pick_idx_d;
        grant_q    <= pick_onehot_d;
        row_sel_q  <= req_addr_i[pick_idx_d];
        row_data_q <= req_data_i[pick_idx_d];
        row_we_q   <= 1'b1;
        state_q    <= BUSY;
      end else begin
        row_we_q <= 1'b0;
      end
    end else begin
      if (wr_cnt_q == LAST_CNT) begin
        state_q  <= IDLE;
        row_we_q <= 1'b0;
        grant_q  <= '0;
        wr_cnt_q <= '0;
        rr_ptr_q <= rr_ptr_d;
      end else begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
    end
  end

  assign req_ready_o = last_cycle ? grant_q : '0;
  assign grant_o     = grant_q;
  assign row_sel_o   = row_sel_q;
  assign row_data_o  = row_data_q;
  assign row_we_o    = row_we_q;

endmodule

// File: doc/mem_col_wr_arbiter.md
Name: mem_col_wr_arbiter

Overview:
Round-robin write arbiter and sequencer for one memory column. NUM_REQ requesters each present a row address and data. The block grants one requester at a time and drives the column's 1-to-NUM_ROWS row demux select, data and write-enable. It holds them stable for WR_CYCLES clocks, then completes the granted requester's valid/ready handshake. It sits between the column's client ports and the row demux/decoder datapath.

Parameters:
NUM_REQ, 4, number of requesters (≥2).
NUM_ROWS, 1024, rows in the column; select width AW = $clog2(NUM_ROWS).
DATA_WIDTH, 8, width of one row element.
WR_CYCLES, 2, cycles row_we_o is held per write (≥1).

Ports:
clk_i  input  1  clock; all logic on the rising edge.
rst_i  input  1  synchronous, active-high reset.
req_valid_i  input  NUM_REQ  per-requester write request.
req_addr_i  input  NUM_REQ x AW  per-requester row address.
req_data_i  input  NUM_REQ x DATA_WIDTH  per-requester write data.
req_ready_o  output  NUM_REQ  one-hot, single-cycle write-complete handshake.
grant_o  output  NUM_REQ  one-hot currently-granted requester.
row_sel_o  output  AW  demux select (row index).
row_data_o  output  DATA_WIDTH  data into demux.
row_we_o  output  1  column write enable.

Behaviour:
- Reset: rst_i high at a clock edge forces the following state, regardless of state:
  - FSM to IDLE; rr_ptr=0; wr_cnt=0.
  - grant_o, row_sel_o, row_data_o, row_we_o all 0; req_ready_o=0.
- Reset mid-BUSY aborts the write. No ready pulse is issued for the aborted request.
- States are IDLE and BUSY.
- IDLE:
  - If any req_valid_i bit is set, pick the winner. It is the first set bit searching upward from rr_ptr, wrapping NUM_REQ-1 → 0.
  - Register winner index, req_addr_i[w] → row_sel_o, req_data_i[w] → row_data_o. Set grant_o one-hot, row_we_o=1, wr_cnt=0, and go to BUSY.
  - If no valid: stay in IDLE with row_we_o=0. row_sel_o and row_data_o hold their last values.
- BUSY:
  - row_we_o=1. row_sel_o, row_data_o and grant_o are stable. wr_cnt increments each cycle.
  - req_ready_o[w] is asserted combinationally when wr_cnt==WR_CYCLES-1. This is the last BUSY cycle.
  - On that edge: go to IDLE, row_we_o=0, grant_o=0, rr_ptr=(w+1) mod NUM_REQ.
- Timing:
  - Valid sampled in IDLE at edge N.
  - row_we_o high for cycles N+1 .. N+WR_CYCLES.
  - Ready in cycle N+WR_CYCLES.
  - One mandatory IDLE cycle between writes, so peak throughput is 1 write per WR_CYCLES+1 cycles.
- Handshake rules:
  - A requester keeps req_valid_i high until it sees its req_ready_o bit.
  - Address and data are sampled only at grant. Changes after grant do not affect the write in flight.
  - The transfer completes when valid & ready are both high.
  - A requester that drops valid while granted still has its write completed and still receives ready.
- Requests arriving during BUSY wait and are arbitrated in the next IDLE.
- Simultaneous requests: exactly one grant. Round-robin guarantees each persistent requester is served within NUM_REQ grants.
- The same requester may be re-granted immediately if it is the only one valid.
- row_sel_o is always < NUM_ROWS when requesters obey the address range. Out-of-range addresses are passed through unchanged; the demux leaves them unwritten.
- grant_o and req_ready_o are never multi-hot. req_ready_o is 0 outside the last BUSY cycle.

Optional Feature:
Macro MEM_COL_WR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid requester always wins; rr_ptr is not implemented (stays 0).
- Undefined: round-robin as described in Behaviour.
- All other timing and handshake behaviour is identical in both builds.

Test Plan:
1. Reset then idle: rst_i=1 for 2 cycles, all valids 0. Required: all outputs 0 for 10 cycles.
2. Single write: req1 valid with addr=0x3FF, data=0xA5 at edge N. Required:
   - row_we_o=1, row_sel_o=0x3FF, row_data_o=0xA5, grant_o=4'b0010 during N+1..N+2.
   - req_ready_o=4'b0010 only in cycle N+2.
   - row_we_o=0 in cycle N+3.
3. Round-robin contention: all 4 valid and held. Required:
   - Grant order 0,1,2,3,0, each grant spaced 3 cycles apart.
   - With MEM_COL_WR_ARB_FIXED_PRIO_EN defined, req0 wins every time while it stays valid.
4. Payload change after grant: req2 is granted with addr=5, data=0x11; the bench changes it to addr=9, data=0x22 in the next cycle. Required: row_sel_o stays 5 and row_data_o stays 0x11 until ready.
5. Reset mid-write: req3 is granted, and rst_i=1 in the first BUSY cycle. Required:
   - Outputs 0 next cycle and req_ready_o never pulses.
   - After reset deasserts with req3 still valid, req3 is re-granted from rr_ptr=0.
6. Wrap-around: only req3 valid, served, then req0 and req3 both valid. Required: req0 granted next (rr_ptr wrapped to 0), then req3.
